// File: rtl/imem_sync_fetch_if.sv
// Fetch/response handshake and program-load write bus of the synchronous instruction memory.
// master: IF-stage PC logic and loader; slave: imem_sync_fetch.
interface imem_sync_fetch_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_err;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;

  modport master (
    output req_valid, req_addr, rsp_ready, wr_en, wr_addr, wr_data,
    input  req_ready, rsp_valid, rsp_data, rsp_err
  );

  modport slave (
    input  req_valid, req_addr, rsp_ready, wr_en, wr_addr, wr_data,
    output req_ready, rsp_valid, rsp_data, rsp_err
  );
endinterface

// File: rtl/imem_sync_fetch.sv
// Synchronous instruction memory: one fetch per cycle, 1-cycle read latency, runtime program load,
// address error flag and saturating fetch counter. Optional squash port under `IMEM_FLUSH_EN`.
module imem_sync_fetch #(
  parameter int                ADDR_W   = 32,
  parameter int                DATA_W   = 32,
  parameter int                DEPTH    = 256,
  parameter logic [DATA_W-1:0] NOP_WORD = 32'h0000_0000,
  parameter int                CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
`ifdef IMEM_FLUSH_EN
  input  logic              flush,
`endif
  imem_sync_fetch_if.slave  bus,
  output logic [CNT_W-1:0]  fetch_cnt
);

  localparam int IDX_W = $clog2(DEPTH);

  // A byte address is usable only when word aligned and below DEPTH words.
  function automatic logic addr_ok(input logic [ADDR_W-1:0] addr);
    logic [ADDR_W-1:0] upper;
    upper   = addr >> (IDX_W + 2);
    addr_ok = (addr[1:0] == 2'b00) && (upper == '0);
  endfunction

  function automatic logic [IDX_W-1:0] addr_idx(input logic [ADDR_W-1:0] addr);
    addr_idx = addr[IDX_W+1:2];
  endfunction

  // Storage is never reset; locations start out holding NOP_WORD.
  logic [DATA_W-1:0] mem_r [DEPTH] = '{default: NOP_WORD};

  logic              rsp_valid_r;
  logic              rsp_err_r;
  logic [DATA_W-1:0] rsp_data_r;
  logic [CNT_W-1:0]  fetch_cnt_r;

  logic              rsp_valid_s;
  logic              rsp_err_s;
  logic [DATA_W-1:0] rsp_data_s;
  logic [CNT_W-1:0]  fetch_cnt_s;
  logic              flush_s;
  logic              req_ready_s;
  logic              accept_s;
  logic              rd_ok_s;
  logic [DATA_W-1:0] rd_word_s;

`ifdef IMEM_FLUSH_EN
  assign flush_s = flush;
`else
  assign flush_s = 1'b0;
`endif

  assign req_ready_s = !flush_s && (!rsp_valid_r || bus.rsp_ready);
  assign accept_s    = bus.req_valid && req_ready_s;
  assign rd_ok_s     = addr_ok(bus.req_addr);
  // Read happens before this edge's write lands, so a colliding fetch sees the old word.
  assign rd_word_s   = mem_r[addr_idx(bus.req_addr)];

  // Response register and counter next-state; flush outranks accept and stall.
  always_comb begin
    rsp_valid_s = rsp_valid_r;
    rsp_err_s   = rsp_err_r;
    rsp_data_s  = rsp_data_r;
    fetch_cnt_s = fetch_cnt_r;
    if (flush_s) begin
      rsp_valid_s = 1'b0;
      rsp_err_s   = 1'b0;
      rsp_data_s  = NOP_WORD;
    end else if (accept_s) begin
      rsp_valid_s = 1'b1;
      rsp_err_s   = !rd_ok_s;
      rsp_data_s  = rd_ok_s ? rd_word_s : NOP_WORD;
    end else if (bus.rsp_ready) begin
      rsp_valid_s = 1'b0;
    end else begin
      rsp_valid_s = rsp_valid_r;
    end
    if (accept_s && (fetch_cnt_r != {CNT_W{1'b1}})) begin
      fetch_cnt_s = fetch_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      fetch_cnt_s = fetch_cnt_r;
    end
  end

  // Response and counter state; reset drops any pending response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_r <= 1'b0;
      rsp_err_r   <= 1'b0;
      rsp_data_r  <= NOP_WORD;
      fetch_cnt_r <= {CNT_W{1'b0}};
    end else begin
      rsp_valid_r <= rsp_valid_s;
      rsp_err_r   <= rsp_err_s;
      rsp_data_r  <= rsp_data_s;
      fetch_cnt_r <= fetch_cnt_s;
    end
  end

  // Program-load port; bad addresses are dropped silently.
  always_ff @(posedge clk) begin
    if (bus.wr_en && addr_ok(bus.wr_addr)) begin
      mem_r[addr_idx(bus.wr_addr)] <= bus.wr_data;
    end
  end

  assign bus.req_ready = req_ready_s;
  assign bus.rsp_valid = rsp_valid_r;
  assign bus.rsp_err   = rsp_err_r;
  assign bus.rsp_data  = rsp_data_r;
  assign fetch_cnt     = fetch_cnt_r;

endmodule

// File: tb/tb_imem_sync_fetch.sv
// Directed bench for imem_sync_fetch: load, fetch, stall, errors, collision, reset, flush, saturation.
module tb_imem_sync_fetch;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  logic [15:0] cnt;
  logic [1:0]  cnt2;
  int checks = 0;
  int failures = 0;

  imem_sync_fetch_if #(.ADDR_W(32), .DATA_W(32)) bus ();
  imem_sync_fetch_if #(.ADDR_W(32), .DATA_W(32)) bus2 ();

  imem_sync_fetch #(.DEPTH(256), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
`ifdef IMEM_FLUSH_EN
    .flush(flush),
`endif
    .bus(bus.slave), .fetch_cnt(cnt)
  );

  imem_sync_fetch #(.DEPTH(256), .CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n),
`ifdef IMEM_FLUSH_EN
    .flush(1'b0),
`endif
    .bus(bus2.slave), .fetch_cnt(cnt2)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    bus.wr_en = 1'b1; bus.wr_addr = a; bus.wr_data = d;
    step();
    bus.wr_en = 1'b0;
  endtask

  initial begin
    bus.req_valid = 1'b0; bus.req_addr = 32'h0; bus.rsp_ready = 1'b0;
    bus.wr_en = 1'b0; bus.wr_addr = 32'h0; bus.wr_data = 32'h0;
    bus2.req_valid = 1'b0; bus2.req_addr = 32'h0; bus2.rsp_ready = 1'b1;
    bus2.wr_en = 1'b0; bus2.wr_addr = 32'h0; bus2.wr_data = 32'h0;
    #12;
    check("rst_valid", {31'h0, bus.rsp_valid}, 32'h0);
    check("rst_err",   {31'h0, bus.rsp_err},   32'h0);
    check("rst_data",  bus.rsp_data,           32'h0);
    check("rst_cnt",   {16'h0, cnt},           32'h0);
    check("rst_ready", {31'h0, bus.req_ready}, 32'h1);
    rst_n = 1'b1;
    step();

    // program load
    wr(32'h0, 32'h2008_0002);
    wr(32'h4, 32'h200A_0002);
    wr(32'h8, 32'hDEAD_BEEF);
    wr(32'hC, 32'h1234_5678);

    // back-to-back fetches
    bus.rsp_ready = 1'b1; bus.req_valid = 1'b1; bus.req_addr = 32'h0;
    step();
    check("b2b0_valid", {31'h0, bus.rsp_valid}, 32'h1);
    check("b2b0_data",  bus.rsp_data,           32'h2008_0002);
    bus.req_addr = 32'h4;
    step();
    check("b2b1_valid", {31'h0, bus.rsp_valid}, 32'h1);
    check("b2b1_data",  bus.rsp_data,           32'h200A_0002);
    check("b2b1_err",   {31'h0, bus.rsp_err},   32'h0);
    check("b2b_cnt",    {16'h0, cnt},           32'h2);
    bus.req_valid = 1'b0;
    step();
    check("drain_valid", {31'h0, bus.rsp_valid}, 32'h0);
    check("drain_hold",  bus.rsp_data,           32'h200A_0002);

    // stall
    bus.rsp_ready = 1'b0; bus.req_valid = 1'b1; bus.req_addr = 32'h8;
    step();
    bus.req_addr = 32'hC;
    for (int i = 0; i < 3; i++) begin
      check("stall_ready", {31'h0, bus.req_ready}, 32'h0);
      check("stall_data",  bus.rsp_data,           32'hDEAD_BEEF);
      check("stall_valid", {31'h0, bus.rsp_valid}, 32'h1);
      check("stall_cnt",   {16'h0, cnt},           32'h3);
      step();
    end
    bus.rsp_ready = 1'b1;
    #1;
    check("release_ready", {31'h0, bus.req_ready}, 32'h1);
    step();
    check("release_data", bus.rsp_data, 32'h1234_5678);
    check("release_cnt",  {16'h0, cnt}, 32'h4);

    // address errors, with bad writes that would alias onto word 0
    bus.req_addr = 32'h6;
    bus.wr_en = 1'b1; bus.wr_addr = 32'h400; bus.wr_data = 32'hBAD0_BAD0;
    step();
    check("mis_err",  {31'h0, bus.rsp_err}, 32'h1);
    check("mis_data", bus.rsp_data,         32'h0);
    bus.req_addr = 32'h400;
    bus.wr_addr = 32'h2;
    step();
    bus.wr_en = 1'b0;
    check("oor_err",   {31'h0, bus.rsp_err},   32'h1);
    check("oor_data",  bus.rsp_data,           32'h0);
    check("oor_valid", {31'h0, bus.rsp_valid}, 32'h1);
    check("err_cnt",   {16'h0, cnt},           32'h6);

    // same-edge fetch and write
    bus.req_addr = 32'h10;
    bus.wr_en = 1'b1; bus.wr_addr = 32'h10; bus.wr_data = 32'h0800_0017;
    step();
    bus.wr_en = 1'b0;
    check("rbw_old", bus.rsp_data,         32'h0);
    check("rbw_err", {31'h0, bus.rsp_err}, 32'h0);
    step();
    check("rbw_new", bus.rsp_data, 32'h0800_0017);
    bus.req_addr = 32'h0;
    step();
    check("noalias_data", bus.rsp_data, 32'h2008_0002);
    check("rbw_cnt",      {16'h0, cnt}, 32'h9);
    bus.req_valid = 1'b0;
    step();

    // reset mid-stall
    bus.rsp_ready = 1'b0; bus.req_valid = 1'b1; bus.req_addr = 32'h4;
    step();
    bus.req_valid = 1'b0;
    check("pre_rst_valid", {31'h0, bus.rsp_valid}, 32'h1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid", {31'h0, bus.rsp_valid}, 32'h0);
    check("arst_cnt",   {16'h0, cnt},           32'h0);
    check("arst_data",  bus.rsp_data,           32'h0);
    #3 rst_n = 1'b1;
    step();
    bus.rsp_ready = 1'b1; bus.req_valid = 1'b1; bus.req_addr = 32'h4;
    step();
    check("keep_mem", bus.rsp_data, 32'h200A_0002);
    check("keep_cnt", {16'h0, cnt}, 32'h1);
    bus.req_valid = 1'b0;
    step();

`ifdef IMEM_FLUSH_EN
    bus.rsp_ready = 1'b0; bus.req_valid = 1'b1; bus.req_addr = 32'h0;
    step();
    check("fl_pre_valid", {31'h0, bus.rsp_valid}, 32'h1);
    flush = 1'b1;
    #1;
    check("fl_ready", {31'h0, bus.req_ready}, 32'h0);
    step();
    flush = 1'b0;
    bus.req_valid = 1'b0;
    check("fl_valid", {31'h0, bus.rsp_valid}, 32'h0);
    check("fl_data",  bus.rsp_data,           32'h0);
    check("fl_err",   {31'h0, bus.rsp_err},   32'h0);
    check("fl_cnt",   {16'h0, cnt},           32'h2);
    bus.rsp_ready = 1'b1;
    step();
`endif

    // saturation on the CNT_W=2 instance
    bus2.req_valid = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      step();
      check("sat_cnt", {30'h0, cnt2}, (i < 3) ? i : 32'h3);
    end
    bus2.req_valid = 1'b0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
